// File: rtl/la_pkg.sv
// Shared types and helpers for the logic-analyzer readout block.
package la_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT,
    HDR,
    DATA,
    CKSUM
  } la_rd_state_t;

  localparam logic [7:0] LA_HEADER_DEFAULT = 8'hA5;

  function automatic int la_bytes_per_entry(input int len);
    return (len + 7) / 8;
  endfunction

endpackage

// File: rtl/la_byte_sel.sv
// Combinational byte picker: byte b (0 = least significant) of entry e,
// with the entry zero-extended to 32 bits.
module la_byte_sel
  import la_pkg::*;
#(
  parameter int ENTRY_LENGTH = 16,
  parameter int NUM_ENTRY    = 15
) (
  input  logic [NUM_ENTRY-1:0][ENTRY_LENGTH-1:0] snap_i,
  input  logic [4:0]                             entry_i,
  input  logic [1:0]                             byte_i,
  output logic [7:0]                             byte_o
);

  logic [31:0] word;

  always_comb begin
    word = '0;
    for (int unsigned e = 0; e < NUM_ENTRY; e++) begin
      if (entry_i == 5'(e)) word[ENTRY_LENGTH-1:0] = snap_i[e];
    end
    case (byte_i)
      2'd0:    byte_o = word[7:0];
      2'd1:    byte_o = word[15:8];
      2'd2:    byte_o = word[23:16];
      default: byte_o = word[31:24];
    endcase
  end

endmodule

// File: rtl/la_readout.sv
// Host-side readout for the delay-line logic analyzer: trigger, wait, latch,
// then stream a framed byte sequence. Optional checksum: LA_READOUT_CKSUM_EN.
module la_readout
  import la_pkg::*;
#(
  parameter int         ENTRY_LENGTH   = 16,
  parameter int         NUM_ENTRY      = 15,
  parameter int         TRIG_HOLD      = 4,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] HEADER_BYTE    = LA_HEADER_DEFAULT
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   arm,
  output logic                                   trig_begin,
  input  logic                                   trig_end,
  input  logic [NUM_ENTRY-1:0][ENTRY_LENGTH-1:0] shift_in,
  output logic [7:0]                             tx_data,
  output logic                                   tx_valid,
  input  logic                                   tx_ready,
  output logic                                   busy,
  output logic                                   timeout_err
);

  localparam int BPE   = la_bytes_per_entry(ENTRY_LENGTH);
  localparam int HLD_W = $clog2(TRIG_HOLD + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  la_rd_state_t                           state_q, state_d;
  logic [HLD_W-1:0]                       hold_q, hold_d;
  logic [TMR_W-1:0]                       timer_q, timer_d;
  logic [4:0]                             entry_q, entry_d;
  logic [1:0]                             byte_q, byte_d;
  logic [NUM_ENTRY-1:0][ENTRY_LENGTH-1:0] snap_q, snap_d;
  logic                                   terr_q, terr_d;
  logic                                   capture;
  logic [7:0]                             sel_byte;
`ifdef LA_READOUT_CKSUM_EN
  logic [7:0]                             cks_q, cks_d;
`endif

  la_byte_sel #(
    .ENTRY_LENGTH(ENTRY_LENGTH),
    .NUM_ENTRY   (NUM_ENTRY)
  ) u_byte_sel (
    .snap_i (snap_q),
    .entry_i(entry_q),
    .byte_i (byte_q),
    .byte_o (sel_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      timer_q <= '0;
      entry_q <= '0;
      byte_q  <= '0;
      snap_q  <= '0;
      terr_q  <= 1'b0;
`ifdef LA_READOUT_CKSUM_EN
      cks_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      timer_q <= timer_d;
      entry_q <= entry_d;
      byte_q  <= byte_d;
      snap_q  <= snap_d;
      terr_q  <= terr_d;
`ifdef LA_READOUT_CKSUM_EN
      cks_q   <= cks_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    timer_d    = timer_q;
    entry_d    = entry_q;
    byte_d     = byte_q;
    snap_d     = snap_q;
    terr_d     = terr_q;
`ifdef LA_READOUT_CKSUM_EN
    cks_d      = cks_q;
`endif
    capture    = 1'b0;
    trig_begin = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    busy       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = TRIG;
          terr_d  = 1'b0;
          hold_d  = '0;
          timer_d = '0;
          entry_d = '0;
          byte_d  = '0;
`ifdef LA_READOUT_CKSUM_EN
          cks_d   = '0;
`endif
        end
      end
      TRIG: begin
        trig_begin = 1'b1;
        if (trig_end) begin
          capture = 1'b1;
        end else if (hold_q == HLD_W'(TRIG_HOLD - 1)) begin
          state_d = WAIT;
          timer_d = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      WAIT: begin
        if (trig_end) begin
          capture = 1'b1;
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = HEADER_BYTE;
        if (tx_ready) state_d = DATA;
      end
      DATA: begin
        tx_valid = 1'b1;
        tx_data  = sel_byte;
        if (tx_ready) begin
`ifdef LA_READOUT_CKSUM_EN
          cks_d = cks_q ^ sel_byte;
`endif
          // Byte index counts down inside an entry; entries count down to 0.
          if (byte_q == 2'd0) begin
            if (entry_q == 5'd0) begin
`ifdef LA_READOUT_CKSUM_EN
              state_d = CKSUM;
`else
              state_d = IDLE;
`endif
            end else begin
              entry_d = entry_q - 5'd1;
              byte_d  = 2'(BPE - 1);
            end
          end else begin
            byte_d = byte_q - 2'd1;
          end
        end
      end
`ifdef LA_READOUT_CKSUM_EN
      CKSUM: begin
        tx_valid = 1'b1;
        tx_data  = cks_q;
        if (tx_ready) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (capture) begin
      snap_d  = shift_in;
      entry_d = 5'(NUM_ENTRY - 1);
      byte_d  = 2'(BPE - 1);
      state_d = HDR;
    end
  end

  assign timeout_err = terr_q;

endmodule
